multi_product_vending_machine: RTL and testbench
================================================

MULTI_PRODUCT_VENDING_MACHINE -- requirements
Module: multi_product_vending_machine

Interface
REQ-001 SHALL have parameter AMT_W, default 8: width of credit and change amounts, in units.
REQ-002 SHALL have parameter NUM_PRODUCTS, default 4: number of product slots.
REQ-003 SHALL have parameters BASE_PRICE, default 7, and PRICE_STEP, default 3: price(i) = BASE_PRICE + i*PRICE_STEP.
REQ-004 SHALL have parameter MAX_CREDIT, default 50: credit ceiling.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-007 SHALL have port coin_valid, input, 1 bit: coin presented this cycle.
REQ-008 SHALL have port coin_value, input, 2 bits: 00=1, 01=2, 10=5, 11=10 units.
REQ-009 SHALL have port sel_valid, input, 1 bit: product selection request.
REQ-010 SHALL have port sel_id, input, clog2(NUM_PRODUCTS) bits: requested product.
REQ-011 SHALL have port cancel, input, 1 bit: refund request.
REQ-012 SHALL have port credit, output, AMT_W bits: current credit.
REQ-013 SHALL have port coin_reject, output, 1 bit: one-cycle pulse, presented coin returned unaccepted.
REQ-014 SHALL have port sel_error, output, 1 bit: one-cycle pulse, selection refused.
REQ-015 SHALL have port dispense_valid, output, 1 bit, and port dispense_id, output, clog2(NUM_PRODUCTS) bits: one-cycle vend pulse and its product.
REQ-016 SHALL have port change_coin_valid, output, 1 bit, and port change_coin_value, output, 2 bits (coin_value encoding): one change coin per cycle.
REQ-017 SHALL have port busy, output, 1 bit: high in VEND and CHANGE.

Function
REQ-018 SHALL implement states IDLE (credit 0), CREDIT (credit > 0), VEND and CHANGE.
REQ-019 SHALL, in IDLE/CREDIT, add an accepted coin to credit next cycle and enter CREDIT.
REQ-020 SHALL reject a coin (coin_reject next cycle, credit unchanged) if credit + value > MAX_CREDIT, if in VEND/CHANGE, or if sel_valid or cancel is asserted in the same cycle.
REQ-021 SHALL evaluate simultaneous events with priority cancel > sel_valid > coin_valid.
REQ-022 SHALL, on sel_valid in CREDIT with sel_id < NUM_PRODUCTS and credit >= price(sel_id), subtract price, latch sel_id and enter VEND.
REQ-023 SHALL pulse sel_error next cycle, credit unchanged, on sel_id >= NUM_PRODUCTS, insufficient credit, or sel_valid in IDLE/VEND/CHANGE.
REQ-024 SHALL assert dispense_valid with dispense_id for exactly the one cycle in VEND, i.e. one cycle after sel_valid accepted.
REQ-025 SHALL leave VEND for CHANGE if remaining credit > 0, else for IDLE.
REQ-026 SHALL, on cancel in CREDIT, enter CHANGE without vending; cancel in IDLE/VEND/CHANGE is ignored.
REQ-027 SHALL, in CHANGE, emit each cycle the largest coin <= credit and subtract it, returning to IDLE the cycle credit reaches 0.
REQ-028 SHALL hold change_coin_valid, dispense_valid, coin_reject and sel_error low except as specified; only coin_reject/sel_error may coincide with others.
REQ-029 SHALL never wrap credit; MAX_CREDIT <= 2^AMT_W - 1 is a parameter legality rule.

Reset
REQ-030 SHALL, on reset low at a clock edge, enter IDLE and drive credit=0 and all pulse outputs, busy, dispense_id and change_coin_value to 0.
REQ-031 SHALL discard credit and pending change when reset occurs mid-operation; no change coin follows reset.
REQ-032 SHALL ignore coin_valid, sel_valid and cancel in the reset cycle.

Configuration
REQ-033 SHALL, with VEND_STOCK_EN defined, keep per-product 4-bit stock counters initialised to 15 at reset, decrement on dispense, and pulse sel_error on selecting a product at 0, credit unchanged.
REQ-034 SHALL, without VEND_STOCK_EN, treat stock as unlimited and contain no stock logic.

Verification
REQ-035 SHALL cover: coins 5,2 then sel_id=0 -> credit 7, dispense_valid id 0 one cycle after select, no change, IDLE.
REQ-036 SHALL cover: coins 10,5 then sel_id=1 (price 10) -> dispense id 1, then one change coin value 5 (code 10), IDLE.
REQ-037 SHALL cover: coins 10,2,1 then cancel -> change coins 10,2,1 on consecutive cycles, credit 0.
REQ-038 SHALL cover: credit 45, coin 10 -> coin_reject, credit stays 45; same-cycle coin and cancel -> cancel taken, coin_reject.
REQ-039 SHALL cover: credit 12, sel_id=2 (price 13) -> sel_error, credit 12; sel_id=3 with NUM_PRODUCTS=3 -> sel_error.
REQ-040 SHALL cover: reset low during CHANGE with credit 8 remaining -> next cycle IDLE, credit 0, no further change coins.

Source files
------------

// File: rtl/multi_product_vending_machine.sv
// rtl/multi_product_vending_machine.sv - multi-product coin vending controller with change return
//
// Purpose: accepts coins (1/2/5/10 units) up to MAX_CREDIT, vends product i at
//   BASE_PRICE + i*PRICE_STEP, and returns leftover credit as change, one coin
//   per cycle, largest denomination first.
// Ports:
//   clk, reset (sync, active low)
//   coin_valid/coin_value      : coin presented (00=1, 01=2, 10=5, 11=10)
//   sel_valid/sel_id           : product selection
//   cancel                     : refund request
//   credit                     : current credit
//   coin_reject, sel_error     : one-cycle refusal pulses
//   dispense_valid/dispense_id : one-cycle vend pulse
//   change_coin_valid/_value   : one change coin per cycle
//   busy                       : high while vending or returning change
// Build option: define VEND_STOCK_EN for per-product 4-bit stock counters.
module multi_product_vending_machine #(
  parameter int AMT_W        = 8,
  parameter int NUM_PRODUCTS = 4,
  parameter int BASE_PRICE   = 7,
  parameter int PRICE_STEP   = 3,
  parameter int MAX_CREDIT   = 50,
  localparam int SEL_W = (NUM_PRODUCTS > 1) ? $clog2(NUM_PRODUCTS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             coin_valid,
  input  logic [1:0]       coin_value,
  input  logic             sel_valid,
  input  logic [SEL_W-1:0] sel_id,
  input  logic             cancel,
  output logic [AMT_W-1:0] credit,
  output logic             coin_reject,
  output logic             sel_error,
  output logic             dispense_valid,
  output logic [SEL_W-1:0] dispense_id,
  output logic             change_coin_valid,
  output logic [1:0]       change_coin_value,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, CREDIT, VEND, CHANGE} state_t;

  function automatic logic [AMT_W-1:0] coin_amt(input logic [1:0] code);
    case (code)
      2'b00:   coin_amt = AMT_W'(1);
      2'b01:   coin_amt = AMT_W'(2);
      2'b10:   coin_amt = AMT_W'(5);
      default: coin_amt = AMT_W'(10);
    endcase
  endfunction

  function automatic logic [1:0] largest_coin(input logic [AMT_W-1:0] amt);
    if (amt >= AMT_W'(10))     largest_coin = 2'b11;
    else if (amt >= AMT_W'(5)) largest_coin = 2'b10;
    else if (amt >= AMT_W'(2)) largest_coin = 2'b01;
    else                       largest_coin = 2'b00;
  endfunction

  function automatic logic [AMT_W-1:0] price_of(input logic [SEL_W-1:0] id);
    price_of = AMT_W'(BASE_PRICE + PRICE_STEP * int'(id));
  endfunction

  state_t           state_q, state_d;
  logic [AMT_W-1:0] credit_q, credit_d;
  logic             coin_reject_q, coin_reject_d;
  logic             sel_error_q, sel_error_d;
  logic             dispense_valid_q, dispense_valid_d;
  logic [SEL_W-1:0] dispense_id_q, dispense_id_d;
  logic             change_valid_q, change_valid_d;
  logic [1:0]       change_value_q, change_value_d;
  logic             busy_q, busy_d;

  logic [AMT_W:0]   coin_sum;
  logic             over_max;
  logic             sel_ok;
  logic             in_stock;

`ifdef VEND_STOCK_EN
  logic [3:0] stock_q [2**SEL_W];
  logic [3:0] stock_d [2**SEL_W];
  assign in_stock = (stock_q[sel_id] != 4'd0);
`else
  assign in_stock = 1'b1;
`endif

  // One extra bit so the ceiling check cannot wrap.
  assign coin_sum = {1'b0, credit_q} + {1'b0, coin_amt(coin_value)};
  assign over_max = coin_sum > (AMT_W+1)'(MAX_CREDIT);
  assign sel_ok   = (int'(sel_id) < NUM_PRODUCTS) && (credit_q >= price_of(sel_id)) && in_stock;

  always_comb begin
    state_d          = state_q;
    credit_d         = credit_q;
    dispense_id_d    = dispense_id_q;
    dispense_valid_d = 1'b0;
    coin_reject_d    = 1'b0;
    sel_error_d      = 1'b0;
    change_valid_d   = 1'b0;
    change_value_d   = 2'b00;
`ifdef VEND_STOCK_EN
    stock_d = stock_q;
`endif

    // A coin is only taken when nothing else competes for the cycle.
    if (coin_valid && ((state_q == VEND) || (state_q == CHANGE) || sel_valid || cancel || over_max))
      coin_reject_d = 1'b1;

    case (state_q)
      IDLE, CREDIT: begin
        if (cancel && (state_q == CREDIT)) begin
          state_d = CHANGE;
        end else if (sel_valid) begin
          if ((state_q == CREDIT) && sel_ok) begin
            credit_d         = credit_q - price_of(sel_id);
            dispense_id_d    = sel_id;
            dispense_valid_d = 1'b1;
            state_d          = VEND;
`ifdef VEND_STOCK_EN
            stock_d[sel_id] = stock_q[sel_id] - 4'd1;
`endif
          end else begin
            sel_error_d = 1'b1;
          end
        end else if (coin_valid && !coin_reject_d) begin
          credit_d = coin_sum[AMT_W-1:0];
          state_d  = CREDIT;
        end
      end
      VEND: begin
        sel_error_d = sel_valid;
        state_d     = (credit_q != '0) ? CHANGE : IDLE;
      end
      CHANGE: begin
        sel_error_d = sel_valid;
        credit_d    = credit_q - coin_amt(largest_coin(credit_q));
        state_d     = (credit_d == '0) ? IDLE : CHANGE;
      end
      default: state_d = IDLE;
    endcase

    // The coin shown in a CHANGE cycle is the one that cycle's credit pays out.
    if (state_d == CHANGE) begin
      change_valid_d = 1'b1;
      change_value_d = largest_coin(credit_d);
    end
    busy_d = (state_d == VEND) || (state_d == CHANGE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q          <= IDLE;
      credit_q         <= '0;
      coin_reject_q    <= 1'b0;
      sel_error_q      <= 1'b0;
      dispense_valid_q <= 1'b0;
      dispense_id_q    <= '0;
      change_valid_q   <= 1'b0;
      change_value_q   <= 2'b00;
      busy_q           <= 1'b0;
`ifdef VEND_STOCK_EN
      for (int i = 0; i < 2**SEL_W; i++) stock_q[i] <= 4'd15;
`endif
    end else begin
      state_q          <= state_d;
      credit_q         <= credit_d;
      coin_reject_q    <= coin_reject_d;
      sel_error_q      <= sel_error_d;
      dispense_valid_q <= dispense_valid_d;
      dispense_id_q    <= dispense_id_d;
      change_valid_q   <= change_valid_d;
      change_value_q   <= change_value_d;
      busy_q           <= busy_d;
`ifdef VEND_STOCK_EN
      stock_q <= stock_d;
`endif
    end
  end

  assign credit            = credit_q;
  assign coin_reject       = coin_reject_q;
  assign sel_error         = sel_error_q;
  assign dispense_valid    = dispense_valid_q;
  assign dispense_id       = dispense_id_q;
  assign change_coin_valid = change_valid_q;
  assign change_coin_value = change_value_q;
  assign busy              = busy_q;

endmodule

// File: tb/tb_multi_product_vending_machine.sv
// tb/tb_multi_product_vending_machine.sv - scoreboard bench for multi_product_vending_machine
module tb_multi_product_vending_machine;
  localparam int AW = 8;
  localparam int EV_REJ = 100, EV_ERR = 200, EV_DISP = 300, EV_CHG = 400;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic coin_valid = 1'b0;
  logic [1:0] coin_value = 2'b00;
  logic sel_valid = 1'b0;
  logic [1:0] sel_id = 2'b00;
  logic cancel = 1'b0;

  logic [AW-1:0] credit, credit3;
  logic coin_reject, sel_error, dispense_valid, change_coin_valid, busy;
  logic coin_reject3, sel_error3, dispense_valid3, change_coin_valid3, busy3;
  logic [1:0] dispense_id, change_coin_value, dispense_id3, change_coin_value3;

  int vectors = 0;
  int miscompares = 0;
  int exp_q[$];
  int obs_q[$];

  always #5 clk = ~clk;

  multi_product_vending_machine dut (
    .clk(clk), .reset(reset), .coin_valid(coin_valid), .coin_value(coin_value),
    .sel_valid(sel_valid), .sel_id(sel_id), .cancel(cancel), .credit(credit),
    .coin_reject(coin_reject), .sel_error(sel_error), .dispense_valid(dispense_valid),
    .dispense_id(dispense_id), .change_coin_valid(change_coin_valid),
    .change_coin_value(change_coin_value), .busy(busy));

  multi_product_vending_machine #(.NUM_PRODUCTS(3)) dut3 (
    .clk(clk), .reset(reset), .coin_valid(coin_valid), .coin_value(coin_value),
    .sel_valid(sel_valid), .sel_id(sel_id), .cancel(cancel), .credit(credit3),
    .coin_reject(coin_reject3), .sel_error(sel_error3), .dispense_valid(dispense_valid3),
    .dispense_id(dispense_id3), .change_coin_valid(change_coin_valid3),
    .change_coin_value(change_coin_value3), .busy(busy3));

  // Observed output events, recorded mid-cycle in a fixed per-cycle order.
  always @(negedge clk) begin
    if (coin_reject === 1'b1) obs_q.push_back(EV_REJ);
    if (sel_error === 1'b1) obs_q.push_back(EV_ERR);
    if (dispense_valid === 1'b1) obs_q.push_back(EV_DISP + int'(dispense_id));
    if (change_coin_valid === 1'b1) obs_q.push_back(EV_CHG + int'(change_coin_value));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; coin_valid = 1'b0; sel_valid = 1'b0; cancel = 1'b0;
    tick(); tick();
    reset = 1'b1;
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic put_coin(input logic [1:0] v);
    coin_valid = 1'b1; coin_value = v;
    tick();
    coin_valid = 1'b0;
  endtask

  task automatic select(input logic [1:0] id);
    sel_valid = 1'b1; sel_id = id;
    tick();
    sel_valid = 1'b0;
  endtask

  task automatic test_reset();
    int e, o;
    reset = 1'b0; coin_valid = 1'b1; coin_value = 2'b11; sel_valid = 1'b1; cancel = 1'b1;
    tick(); tick();
    vectors++;
    if ({credit, busy, dispense_valid, change_coin_valid, coin_reject, sel_error, dispense_id, change_coin_value} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: credit=%0d busy=%b dv=%b cv=%b cr=%b se=%b required all 0",
               credit, busy, dispense_valid, change_coin_valid, coin_reject, sel_error);
    end
    coin_valid = 1'b0; sel_valid = 1'b0; cancel = 1'b0; reset = 1'b1;
    exp_q.delete(); obs_q.delete();
    tick(); tick();
    vectors++;
    if (credit !== 8'd0) begin miscompares++; $display("FAIL reset_ignore_inputs: credit=%0d required 0", credit); end
    vectors++;
    if (obs_q.size() != 0) begin miscompares++; $display("FAIL reset_no_events: got %0d events required 0", obs_q.size()); end
  endtask

  task automatic test_exact_vend();
    int e, o;
    do_reset();
    put_coin(2'b10); put_coin(2'b01);
    vectors++;
    if (credit !== 8'd7) begin miscompares++; $display("FAIL exact_credit: credit=%0d required 7", credit); end
    exp_q.push_back(EV_DISP + 0);
    select(2'd0);
    vectors++;
    if ({dispense_valid, dispense_id, busy, credit} !== {1'b1, 2'd0, 1'b1, 8'd0}) begin
      miscompares++;
      $display("FAIL exact_vend: dv=%b id=%0d busy=%b credit=%0d required 1 0 1 0", dispense_valid, dispense_id, busy, credit);
    end
    tick();
    vectors++;
    if ({dispense_valid, busy, change_coin_valid} !== 3'b000) begin
      miscompares++;
      $display("FAIL exact_idle: dv=%b busy=%b cv=%b required 0 0 0", dispense_valid, busy, change_coin_valid);
    end
    tick();
    vectors++;
    if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL exact_sb_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL exact_sb_event: got %0d required %0d", o, e); end
    end
  endtask

  task automatic test_vend_change();
    int e, o;
    do_reset();
    put_coin(2'b11); put_coin(2'b10);
    vectors++;
    if (credit !== 8'd15) begin miscompares++; $display("FAIL change_credit: credit=%0d required 15", credit); end
    exp_q.push_back(EV_DISP + 1); exp_q.push_back(EV_CHG + 2);
    select(2'd1);
    vectors++;
    if ({dispense_valid, dispense_id, credit} !== {1'b1, 2'd1, 8'd5}) begin
      miscompares++;
      $display("FAIL change_vend: dv=%b id=%0d credit=%0d required 1 1 5", dispense_valid, dispense_id, credit);
    end
    tick();
    vectors++;
    if ({change_coin_valid, change_coin_value, dispense_valid} !== {1'b1, 2'b10, 1'b0}) begin
      miscompares++;
      $display("FAIL change_coin: cv=%b val=%b dv=%b required 1 10 0", change_coin_valid, change_coin_value, dispense_valid);
    end
    tick();
    vectors++;
    if ({busy, credit, change_coin_valid} !== {1'b0, 8'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL change_idle: busy=%b credit=%0d cv=%b required 0 0 0", busy, credit, change_coin_valid);
    end
    tick();
    vectors++;
    if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL change_sb_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL change_sb_event: got %0d required %0d", o, e); end
    end
  endtask

  task automatic test_cancel_refund();
    int e, o;
    logic [1:0] want [3];
    want[0] = 2'b11; want[1] = 2'b01; want[2] = 2'b00;
    do_reset();
    put_coin(2'b11); put_coin(2'b01); put_coin(2'b00);
    vectors++;
    if (credit !== 8'd13) begin miscompares++; $display("FAIL cancel_credit: credit=%0d required 13", credit); end
    for (int i = 0; i < 3; i++) exp_q.push_back(EV_CHG + int'(want[i]));
    cancel = 1'b1; tick(); cancel = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if ({change_coin_valid, change_coin_value} !== {1'b1, want[i]}) begin
        miscompares++;
        $display("FAIL cancel_coin%0d: cv=%b val=%b required 1 %b", i, change_coin_valid, change_coin_value, want[i]);
      end
      tick();
    end
    vectors++;
    if ({change_coin_valid, credit, busy} !== {1'b0, 8'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL cancel_idle: cv=%b credit=%0d busy=%b required 0 0 0", change_coin_valid, credit, busy);
    end
    tick();
    vectors++;
    if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL cancel_sb_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL cancel_sb_event: got %0d required %0d", o, e); end
    end
  endtask

  task automatic test_coin_reject();
    int e, o;
    do_reset();
    for (int i = 0; i < 4; i++) put_coin(2'b11);
    put_coin(2'b10);
    vectors++;
    if (credit !== 8'd45) begin miscompares++; $display("FAIL reject_credit: credit=%0d required 45", credit); end
    exp_q.push_back(EV_REJ);
    put_coin(2'b11);
    vectors++;
    if ({coin_reject, credit} !== {1'b1, 8'd45}) begin
      miscompares++;
      $display("FAIL reject_over: cr=%b credit=%0d required 1 45", coin_reject, credit);
    end
    exp_q.push_back(EV_REJ);
    for (int i = 0; i < 4; i++) exp_q.push_back(EV_CHG + 3);
    exp_q.push_back(EV_CHG + 2);
    coin_valid = 1'b1; coin_value = 2'b10; cancel = 1'b1;
    tick();
    coin_valid = 1'b0; cancel = 1'b0;
    vectors++;
    if ({coin_reject, busy, change_coin_valid, credit} !== {1'b1, 1'b1, 1'b1, 8'd45}) begin
      miscompares++;
      $display("FAIL reject_with_cancel: cr=%b busy=%b cv=%b credit=%0d required 1 1 1 45", coin_reject, busy, change_coin_valid, credit);
    end
    for (int i = 0; i < 40 && busy; i++) tick();
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL reject_timeout: busy=%b required 0", busy); end
    tick();
    vectors++;
    if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL reject_sb_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL reject_sb_event: got %0d required %0d", o, e); end
    end
  endtask

  task automatic test_max_boundary();
    int e, o;
    do_reset();
    for (int i = 0; i < 5; i++) put_coin(2'b11);
    vectors++;
    if ({credit, coin_reject} !== {8'd50, 1'b0}) begin
      miscompares++;
      $display("FAIL max_exact: credit=%0d cr=%b required 50 0", credit, coin_reject);
    end
    exp_q.push_back(EV_REJ);
    put_coin(2'b00);
    vectors++;
    if ({coin_reject, credit} !== {1'b1, 8'd50}) begin
      miscompares++;
      $display("FAIL max_plus_one: cr=%b credit=%0d required 1 50", coin_reject, credit);
    end
    for (int i = 0; i < 5; i++) exp_q.push_back(EV_CHG + 3);
    cancel = 1'b1; tick(); cancel = 1'b0;
    for (int i = 0; i < 40 && busy; i++) tick();
    vectors++;
    if ({busy, credit} !== {1'b0, 8'd0}) begin
      miscompares++;
      $display("FAIL max_drain: busy=%b credit=%0d required 0 0", busy, credit);
    end
    tick();
    vectors++;
    if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL max_sb_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL max_sb_event: got %0d required %0d", o, e); end
    end
  endtask

  task automatic test_sel_error();
    int e, o;
    do_reset();
    exp_q.push_back(EV_ERR);
    select(2'd0);
    vectors++;
    if ({sel_error, busy} !== 2'b10) begin miscompares++; $display("FAIL sel_idle: se=%b busy=%b required 1 0", sel_error, busy); end
    put_coin(2'b11); put_coin(2'b01);
    exp_q.push_back(EV_ERR);
    select(2'd2);
    vectors++;
    if ({sel_error, credit, busy, dispense_valid} !== {1'b1, 8'd12, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL sel_short: se=%b credit=%0d busy=%b dv=%b required 1 12 0 0", sel_error, credit, busy, dispense_valid);
    end
    put_coin(2'b11);
    // Product 3 costs 16: the 4-product machine vends it, the 3-product one refuses.
    exp_q.push_back(EV_DISP + 3); exp_q.push_back(EV_CHG + 2); exp_q.push_back(EV_CHG + 0);
    select(2'd3);
    vectors++;
    if ({sel_error3, credit3, dispense_valid3} !== {1'b1, 8'd22, 1'b0}) begin
      miscompares++;
      $display("FAIL sel_out_of_range: se=%b credit=%0d dv=%b required 1 22 0", sel_error3, credit3, dispense_valid3);
    end
    vectors++;
    if ({dispense_valid, dispense_id, credit, sel_error} !== {1'b1, 2'd3, 8'd6, 1'b0}) begin
      miscompares++;
      $display("FAIL sel_top_product: dv=%b id=%0d credit=%0d se=%b required 1 3 6 0", dispense_valid, dispense_id, credit, sel_error);
    end
    for (int i = 0; i < 40 && busy; i++) tick();
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL sel_timeout: busy=%b required 0", busy); end
    tick();
    vectors++;
    if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL sel_sb_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL sel_sb_event: got %0d required %0d", o, e); end
    end
  endtask

  task automatic test_back_to_back();
    int e, o;
    do_reset();
    put_coin(2'b11); put_coin(2'b11);
    exp_q.push_back(EV_DISP + 0);
    select(2'd0);
    exp_q.push_back(EV_REJ); exp_q.push_back(EV_CHG + 3);
    put_coin(2'b00);
    vectors++;
    if ({coin_reject, change_coin_valid, change_coin_value, credit} !== {1'b1, 1'b1, 2'b11, 8'd13}) begin
      miscompares++;
      $display("FAIL b2b_coin_in_vend: cr=%b cv=%b val=%b credit=%0d required 1 1 11 13", coin_reject, change_coin_valid, change_coin_value, credit);
    end
    exp_q.push_back(EV_ERR); exp_q.push_back(EV_CHG + 1);
    select(2'd0);
    vectors++;
    if ({sel_error, change_coin_value} !== {1'b1, 2'b01}) begin
      miscompares++;
      $display("FAIL b2b_sel_in_change: se=%b val=%b required 1 01", sel_error, change_coin_value);
    end
    exp_q.push_back(EV_CHG + 0);
    for (int i = 0; i < 40 && busy; i++) tick();
    vectors++;
    if ({busy, credit} !== {1'b0, 8'd0}) begin
      miscompares++;
      $display("FAIL b2b_drain: busy=%b credit=%0d required 0 0", busy, credit);
    end
    tick();
    vectors++;
    if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL b2b_sb_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL b2b_sb_event: got %0d required %0d", o, e); end
    end
  endtask

  task automatic test_reset_mid_change();
    int e, o;
    int late_coins;
    do_reset();
    put_coin(2'b11); put_coin(2'b10); put_coin(2'b01); put_coin(2'b00);
    exp_q.push_back(EV_CHG + 3); exp_q.push_back(EV_CHG + 2);
    cancel = 1'b1; tick(); cancel = 1'b0;
    tick();
    vectors++;
    if ({credit, change_coin_valid, change_coin_value} !== {8'd8, 1'b1, 2'b10}) begin
      miscompares++;
      $display("FAIL midrst_pre: credit=%0d cv=%b val=%b required 8 1 10", credit, change_coin_valid, change_coin_value);
    end
    reset = 1'b0;
    tick();
    vectors++;
    if ({credit, busy, change_coin_valid} !== {8'd0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL midrst_idle: credit=%0d busy=%b cv=%b required 0 0 0", credit, busy, change_coin_valid);
    end
    reset = 1'b1;
    late_coins = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (change_coin_valid === 1'b1) late_coins++;
    end
    vectors++;
    if (late_coins != 0) begin miscompares++; $display("FAIL midrst_late_coins: got %0d required 0", late_coins); end
    vectors++;
    if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL midrst_sb_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL midrst_sb_event: got %0d required %0d", o, e); end
    end
  endtask

  initial begin
    test_reset();
    test_exact_vend();
    test_vend_change();
    test_cancel_refund();
    test_coin_reject();
    test_max_boundary();
    test_sel_error();
    test_back_to_back();
    test_reset_mid_change();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
